// File: rtl/bsc_seq_pkg.sv
// bsc_seq_pkg: shared states, command opcodes and control bit positions for the scan sequencer
package bsc_seq_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, SHIFT, UPDATE, RESP} state_e;
  typedef enum logic [1:0] {OP_SHIFT, OP_LOAD_SHIFT, OP_SHIFT_UPDATE, OP_LOAD_SHIFT_UPDATE} op_e;
  localparam int CTRL_SHIFT = 0;
  localparam int CTRL_UPDATE = 1;
  localparam int CTRL_LOAD = 2;
endpackage

// File: rtl/bsc_seq_shift_unit.sv
// bsc_seq_shift_unit: serial tdi source, tdo capture register and shift bit counter
module bsc_seq_shift_unit #(
  parameter int CHAIN_LEN = 8,
  parameter int CNT_W = $clog2(CHAIN_LEN)
) (
  input  logic                 tck,
  input  logic                 trst_n,
  input  logic                 load_i,
  input  logic [CHAIN_LEN-1:0] data_i,
  input  logic                 shift_en_i,
  input  logic                 tdo_i,
  output logic                 tdi_o,
  output logic [CHAIN_LEN-1:0] cap_o,
  output logic                 last_o
);
  logic [CHAIN_LEN-1:0] tdi_sr_q, cap_sr_q;
  logic [CNT_W-1:0] cnt_q;
  assign last_o = cnt_q == CNT_W'(CHAIN_LEN - 1);
  assign tdi_o = tdi_sr_q[0];
  assign cap_o = cap_sr_q;
  always_ff @(posedge tck or negedge trst_n) begin
    if (!trst_n) begin
      tdi_sr_q <= '0;
      cap_sr_q <= '0;
      cnt_q <= '0;
    end else if (load_i) begin
      tdi_sr_q <= data_i;
    end else if (shift_en_i) begin
      tdi_sr_q <= tdi_sr_q >> 1;
      cap_sr_q <= {tdo_i, cap_sr_q[CHAIN_LEN-1:1]};
      cnt_q <= last_o ? '0 : cnt_q + 1'b1;
    end
  end
endmodule

// File: rtl/bsc_sequencer.sv
// bsc_sequencer: command-driven load/shift/update sequencer for one boundary scan chain
module bsc_sequencer
  import bsc_seq_pkg::*;
#(
  parameter int CHAIN_LEN = 8,
  parameter int CNT_W = $clog2(CHAIN_LEN)
) (
  input  logic                 tck,
  input  logic                 trst_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           cmd_op,
  input  logic [CHAIN_LEN-1:0] cmd_tdi_data,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [CHAIN_LEN-1:0] rsp_tdo_data,
  output logic [3:0]           bsc_control,
  output logic                 bsc_tdi,
  input  logic                 bsc_tdo,
  output logic                 busy
);
  state_e state_q, state_d;
  op_e op_q;
  logic accept, last, tdi_bit;
  assign accept = cmd_valid && cmd_ready;
  bsc_seq_shift_unit #(.CHAIN_LEN(CHAIN_LEN), .CNT_W(CNT_W)) u_shift (
    .tck(tck),
    .trst_n(trst_n),
    .load_i(accept),
    .data_i(cmd_tdi_data),
    .shift_en_i(state_q == SHIFT),
    .tdo_i(bsc_tdo),
    .tdi_o(tdi_bit),
    .cap_o(rsp_tdo_data),
    .last_o(last)
  );
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = cmd_valid ? (cmd_op[0] ? LOAD : SHIFT) : IDLE;
      LOAD:    state_d = SHIFT;
      SHIFT:   state_d = !last ? SHIFT : (op_q inside {OP_SHIFT_UPDATE, OP_LOAD_SHIFT_UPDATE}) ? UPDATE : RESP;
      UPDATE:  state_d = RESP;
      RESP:    state_d = rsp_ready ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge tck or negedge trst_n) begin
    if (!trst_n) begin
      state_q <= IDLE;
      op_q <= OP_SHIFT;
    end else begin
      state_q <= state_d;
      if (accept) op_q <= op_e'(cmd_op);
    end
  end
  always_comb begin
    bsc_control = '0;
    bsc_control[CTRL_SHIFT] = state_q == SHIFT;
    bsc_control[CTRL_UPDATE] = state_q == UPDATE;
    bsc_control[CTRL_LOAD] = state_q == LOAD;
  end
  assign bsc_tdi = (state_q == SHIFT) && tdi_bit;
  assign rsp_valid = state_q == RESP;
  assign cmd_ready = state_q == IDLE;
  assign busy = state_q != IDLE;
endmodule

// File: tb/tb_bsc_sequencer.sv
// tb_bsc_sequencer: directed bench with a behavioural 8-cell chain model
module tb_bsc_sequencer;
  logic tck = 0, trst_n = 0, cmd_valid = 0, rsp_ready = 1, bsc_tdi, bsc_tdo, cmd_ready, rsp_valid, busy;
  logic [1:0] cmd_op = 0;
  logic [7:0] cmd_tdi_data = 0, rsp_tdo_data;
  logic [3:0] bsc_control;
  logic [7:0] chain_sr, chain_out, chain_in = 0, preset_val = 0;
  logic preset = 0, mon_ul = 0, bad_ul = 0;
  int checks = 0, errors = 0, cyc = 0, acc_n = 0, last_acc = 0, prev_acc = 0, lat, n0;
  logic rv_seen, stable;
  always #5 tck = ~tck;
  bsc_sequencer dut (
    .tck(tck), .trst_n(trst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_tdi_data(cmd_tdi_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_tdo_data(rsp_tdo_data),
    .bsc_control(bsc_control), .bsc_tdi(bsc_tdi), .bsc_tdo(bsc_tdo), .busy(busy)
  );
  assign bsc_tdo = chain_sr[0];
  always @(posedge tck) begin
    if (preset) chain_sr <= preset_val;
    else if (bsc_control[2]) chain_sr <= chain_in;
    else if (bsc_control[0]) chain_sr <= {bsc_tdi, chain_sr[7:1]};
    if (bsc_control[1]) chain_out <= chain_sr;
    if (mon_ul && (bsc_control[1] || bsc_control[2])) bad_ul <= 1;
    cyc <= cyc + 1;
    if (trst_n && cmd_valid && cmd_ready) begin
      prev_acc <= last_acc;
      last_acc <= cyc;
      acc_n <= acc_n + 1;
    end
  end
  always @(negedge tck)
    assert ($onehot0(bsc_control[2:0]) && !bsc_control[3])
    else begin errors++; $error("FAIL ctrl_onehot: observed %b expected one-hot-or-zero with bit3 clear", bsc_control); end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin errors++; $error("FAIL %s: observed %0h expected %0h", tag, obs, exp); end
  endtask
  task automatic send(input logic [1:0] op, input logic [7:0] d);
    int w = 0;
    while (!cmd_ready && w < 40) begin @(posedge tck); #1; w++; end
    if (w == 40) chk("cmd_ready_timeout", 0, 1);
    cmd_op = op; cmd_tdi_data = d; cmd_valid = 1;
    @(posedge tck); #1;
    cmd_valid = 0;
  endtask
  task automatic wait_rsp(output int l);
    l = 1;
    while (!rsp_valid && l < 40) begin @(posedge tck); #1; l++; end
  endtask
  initial begin
    #12;
    chk("rst_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_ctrl", bsc_control, 0);
    chk("rst_rvalid", rsp_valid, 0);
    chk("rst_data", rsp_tdo_data, 0);
    chk("rst_tdi", bsc_tdi, 0);
    @(posedge tck); #1; trst_n = 1;
    @(posedge tck); #1;
    chain_in = 8'hA5;
    send(2'd3, 8'h3C);
    chk("op3_busy", busy, 1);
    chk("op3_ready", cmd_ready, 0);
    wait_rsp(lat);
    chk("op3_lat", lat, 11);
    chk("op3_data", rsp_tdo_data, 8'hA5);
    chk("op3_chain_out", chain_out, 8'h3C);
    @(posedge tck); #1;
    preset_val = 8'hF0; preset = 1;
    @(posedge tck); #1;
    preset = 0; mon_ul = 1;
    send(2'd0, 8'h0F);
    wait_rsp(lat);
    chk("op0_lat", lat, 9);
    chk("op0_data", rsp_tdo_data, 8'hF0);
    chk("op0_chain_sr", chain_sr, 8'h0F);
    @(posedge tck); #1;
    mon_ul = 0;
    chk("op0_no_ul", bad_ul, 0);
    rsp_ready = 0; chain_in = 8'hC3;
    send(2'd1, 8'h5A);
    wait_rsp(lat);
    chk("op1_lat", lat, 10);
    n0 = acc_n; stable = 1;
    for (int i = 0; i < 5; i++) begin
      cmd_valid = (i % 2 == 0); cmd_op = 2'd3;
      if (!(rsp_valid && rsp_tdo_data == 8'hC3 && !cmd_ready)) stable = 0;
      @(posedge tck); #1;
    end
    cmd_valid = 0;
    chk("hold_stable", stable, 1);
    chk("hold_valid", rsp_valid, 1);
    chk("hold_data", rsp_tdo_data, 8'hC3);
    chk("hold_no_accept", acc_n - n0, 0);
    rsp_ready = 1;
    @(posedge tck); #1;
    chk("hold_done_valid", rsp_valid, 0);
    chk("hold_done_ready", cmd_ready, 1);
    @(posedge tck); #1; @(posedge tck); #1;
    chk("hold_no_second", busy, 0);
    chain_in = 8'h55;
    send(2'd3, 8'hAA);
    for (int i = 0; i < 4; i++) begin @(posedge tck); #1; end
    chk("abort_pre_ctrl", bsc_control, 4'b0001);
    #2 trst_n = 0;
    #1;
    chk("abort_ctrl", bsc_control, 0);
    chk("abort_busy", busy, 0);
    chk("abort_ready", cmd_ready, 1);
    chk("abort_rvalid", rsp_valid, 0);
    @(posedge tck); #1; trst_n = 1;
    rv_seen = 0;
    for (int i = 0; i < 12; i++) begin @(posedge tck); #1; if (rsp_valid || busy) rv_seen = 1; end
    chk("abort_quiet", rv_seen, 0);
    chain_in = 8'h96;
    send(2'd1, 8'h69);
    wait_rsp(lat);
    chk("post_op1_lat", lat, 10);
    chk("post_op1_data", rsp_tdo_data, 8'h96);
    chk("post_op1_sr", chain_sr, 8'h69);
    @(posedge tck); #1;
    n0 = acc_n;
    cmd_op = 2'd2; cmd_tdi_data = 8'h11; cmd_valid = 1;
    for (int i = 0; i < 40 && acc_n != n0 + 1; i++) begin @(posedge tck); #1; end
    cmd_tdi_data = 8'h22;
    wait_rsp(lat);
    chk("b2b1_lat", lat, 10);
    chk("b2b1_data", rsp_tdo_data, 8'h69);
    chk("b2b1_out", chain_out, 8'h11);
    for (int i = 0; i < 40 && acc_n != n0 + 2; i++) begin @(posedge tck); #1; end
    cmd_valid = 0;
    chk("b2b_accepts", acc_n - n0, 2);
    chk("b2b_gap", last_acc - prev_acc, 11);
    wait_rsp(lat);
    chk("b2b2_lat", lat, 10);
    chk("b2b2_data", rsp_tdo_data, 8'h11);
    chk("b2b2_out", chain_out, 8'h22);
    @(posedge tck); #1;
    chk("final_idle", busy, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
